axi4lite_mem_responder: RTL and testbench

- Synthesizable AXI4-Lite responder (memory slave) that terminates the AXI master port of the picorv32 AXI core. Intended for FPGA and emulation builds where the behavioural test memory cannot be used.
- Provides word-addressed RAM with byte strobes, a console byte sink, and a sticky tests-passed flag.
- Read and write channels run independently, each with a configurable response latency.

---
 rtl/axi4lite_mem_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi4lite_mem_responder.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_responder.sv
// axi4lite_mem_responder: AXI4-Lite memory slave for the picorv32 AXI port.
// Word-addressed RAM with byte strobes, console byte sink at CONSOLE_ADDR,
// sticky tests_passed (PASS_VALUE written to PASS_ADDR), sticky addr_error.
// Independent read/write channels, each answering LATENCY+1 cycles after
// the address/data handshake. All outputs registered; sync active-high reset.
module axi4lite_mem_responder #(
  parameter int unsigned MEM_WORDS    = 32768,
  parameter int unsigned LATENCY      = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed,
  output logic        addr_error
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [31:0] memory [0:MEM_WORDS-1];

  w_state_t    w_state, w_state_n;
  r_state_t    r_state, r_state_n;
  logic        aw_held, aw_held_n, w_held, w_held_n;
  logic [31:0] wr_addr, wr_addr_n, wr_data, wr_data_n;
  logic [3:0]  wr_strb, wr_strb_n;
  logic [3:0]  w_cnt, w_cnt_n, r_cnt, r_cnt_n;
  logic [31:0] rd_addr, rd_addr_n;

  logic        awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [31:0] rdata_n;
  logic        console_valid_n, tests_passed_n, addr_error_n;
  logic [7:0]  console_data_n;
  logic        wr_error, rd_error, mem_we;
  logic [31:0] mem_rword;

  logic unused;
  assign unused = ^{mem_axi_awprot, mem_axi_arprot, wr_addr[1:0], rd_addr[1:0]};

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(MEM_WORDS);
  endfunction

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  // Write channel
  always_comb begin
    w_state_n       = w_state;
    aw_held_n       = aw_held;
    w_held_n        = w_held;
    wr_addr_n       = wr_addr;
    wr_data_n       = wr_data;
    wr_strb_n       = wr_strb;
    w_cnt_n         = w_cnt;
    awready_n       = mem_axi_awready;
    wready_n        = mem_axi_wready;
    bvalid_n        = mem_axi_bvalid;
    console_valid_n = 1'b0;
    console_data_n  = console_data;
    tests_passed_n  = tests_passed;
    wr_error        = 1'b0;
    mem_we          = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (mem_axi_awvalid && mem_axi_awready) begin
          aw_held_n = 1'b1;
          wr_addr_n = mem_axi_awaddr;
        end
        if (mem_axi_wvalid && mem_axi_wready) begin
          w_held_n  = 1'b1;
          wr_data_n = mem_axi_wdata;
          wr_strb_n = mem_axi_wstrb;
        end
        // ready tracks "not yet captured"; also raises readies after reset
        awready_n = !aw_held_n;
        wready_n  = !w_held_n;
        if (aw_held_n && w_held_n) begin
          w_state_n = W_WAIT;
          w_cnt_n   = 4'(LATENCY);
        end
      end
      W_WAIT: begin
        if (w_cnt == '0) begin
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          if (same_word(wr_addr, CONSOLE_ADDR)) begin
            console_valid_n = 1'b1;
            console_data_n  = wr_data[7:0];
          end else if (same_word(wr_addr, PASS_ADDR)) begin
            if (wr_data == PASS_VALUE) tests_passed_n = 1'b1;
          end else if (in_range(wr_addr)) begin
            mem_we = !reset;
          end else begin
            wr_error = 1'b1;
          end
        end else begin
          w_cnt_n = w_cnt - 4'd1;
        end
      end
      W_RESP: begin
        if (mem_axi_bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read channel
  always_comb begin
    mem_rword = memory[rd_addr[IDX_W+1:2]];
  end

  always_comb begin
    r_state_n = r_state;
    rd_addr_n = rd_addr;
    r_cnt_n   = r_cnt;
    arready_n = mem_axi_arready;
    rvalid_n  = mem_axi_rvalid;
    rdata_n   = mem_axi_rdata;
    rd_error  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (mem_axi_arvalid && mem_axi_arready) begin
          rd_addr_n = mem_axi_araddr;
          arready_n = 1'b0;
          r_cnt_n   = 4'(LATENCY);
          r_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt == '0) begin
          rvalid_n  = 1'b1;
          r_state_n = R_RESP;
          if (same_word(rd_addr, CONSOLE_ADDR) || same_word(rd_addr, PASS_ADDR)) begin
            rdata_n = '0;
          end else if (in_range(rd_addr)) begin
            rdata_n = mem_rword;
          end else begin
            rdata_n  = '0;
            rd_error = 1'b1;
          end
        end else begin
          r_cnt_n = r_cnt - 4'd1;
        end
      end
      R_RESP: begin
        if (mem_axi_rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    addr_error_n = addr_error | wr_error | rd_error;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state         <= W_IDLE;
      r_state         <= R_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      wr_strb         <= '0;
      w_cnt           <= '0;
      r_cnt           <= '0;
      rd_addr         <= '0;
      mem_axi_awready <= 1'b0;
      mem_axi_wready  <= 1'b0;
      mem_axi_bvalid  <= 1'b0;
      mem_axi_arready <= 1'b0;
      mem_axi_rvalid  <= 1'b0;
      mem_axi_rdata   <= '0;
      console_valid   <= 1'b0;
      console_data    <= '0;
      tests_passed    <= 1'b0;
      addr_error      <= 1'b0;
    end else begin
      w_state         <= w_state_n;
      r_state         <= r_state_n;
      aw_held         <= aw_held_n;
      w_held          <= w_held_n;
      wr_addr         <= wr_addr_n;
      wr_data         <= wr_data_n;
      wr_strb         <= wr_strb_n;
      w_cnt           <= w_cnt_n;
      r_cnt           <= r_cnt_n;
      rd_addr         <= rd_addr_n;
      mem_axi_awready <= awready_n;
      mem_axi_wready  <= wready_n;
      mem_axi_bvalid  <= bvalid_n;
      mem_axi_arready <= arready_n;
      mem_axi_rvalid  <= rvalid_n;
      mem_axi_rdata   <= rdata_n;
      console_valid   <= console_valid_n;
      console_data    <= console_data_n;
      tests_passed    <= tests_passed_n;
      addr_error      <= addr_error_n;
    end
  end

  // RAM is not reset; a read sampled on the commit edge sees the old word
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_strb[i]) memory[wr_addr[IDX_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_responder.sv
module tb_axi4lite_mem_responder;

  localparam int          MEM_WORDS    = 1024;
  localparam int          LATENCY      = 1;
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] PASS_VALUE   = 32'd123456789;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        tests_passed, addr_error;

  always #5 clk = ~clk;

  axi4lite_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .CONSOLE_ADDR(CONSOLE_ADDR),
    .PASS_ADDR(PASS_ADDR), .PASS_VALUE(PASS_VALUE)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata),
    .console_valid(console_valid), .console_data(console_data),
    .tests_passed(tests_passed), .addr_error(addr_error)
  );

  int checks = 0;
  int errors = 0;

  // Console pulses observed mid-cycle
  int         cons_count = 0;
  logic [7:0] cons_last  = 8'h00;
  always @(negedge clk) begin
    if (console_valid === 1'b1) begin
      cons_count++;
      cons_last = console_data;
    end
  end

  // Reference model: word array plus sticky flags
  logic [31:0] model_mem [int];
  logic        model_pass = 1'b0;
  logic        model_err  = 1'b0;

  function automatic bit is_special(input logic [31:0] a);
    return (a[31:2] == CONSOLE_ADDR[31:2]) || (a[31:2] == PASS_ADDR[31:2]);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int          idx;
    logic [31:0] w;
    idx = int'(a[31:2]);
    if (a[31:2] == CONSOLE_ADDR[31:2]) return;
    if (a[31:2] == PASS_ADDR[31:2]) begin
      if (d == PASS_VALUE) model_pass = 1'b1;
      return;
    end
    if (idx >= MEM_WORDS) begin
      model_err = 1'b1;
      return;
    end
    w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model_mem[idx] = w;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[31:2]);
    if (is_special(a)) return 32'h0;
    if (idx >= MEM_WORDS) begin
      model_err = 1'b1;
      return 32'h0;
    end
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  // Bus drivers; all start and end just after a rising edge
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output int lat, output bit wlow_ok, output bit timeout);
    bit awf, wf, aw_done, w_done;
    int cnt;
    mem_axi_awaddr = a; mem_axi_wdata = d; mem_axi_wstrb = s;
    mem_axi_wvalid = 1'b1; mem_axi_bready = 1'b1;
    aw_done = 0; w_done = 0; cnt = 0; lat = -1; wlow_ok = 1; timeout = 1;
    for (int i = 0; i < 64; i++) begin
      if (i == w_lead) mem_axi_awvalid = 1'b1;
      awf = mem_axi_awvalid && mem_axi_awready;
      wf  = mem_axi_wvalid && mem_axi_wready;
      @(posedge clk); #1;
      if (awf) begin mem_axi_awvalid = 1'b0; aw_done = 1; end
      if (wf)  begin mem_axi_wvalid  = 1'b0; w_done  = 1; end
      if (aw_done && w_done && (awf || wf)) cnt = 0; else cnt++;
      if (w_done && mem_axi_wready) wlow_ok = 0;
      if (aw_done && w_done && mem_axi_bvalid) begin lat = cnt; break; end
    end
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0;
    if (lat >= 0) begin
      model_write(a, d, s);
      @(posedge clk); #1;
      timeout = 0;
    end
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] data, output int lat, output bit timeout);
    bit arf, fired;
    int cnt;
    mem_axi_araddr = a; mem_axi_arvalid = 1'b1; mem_axi_rready = 1'b1;
    fired = 0; cnt = 0; lat = -1; timeout = 1; data = 32'h0;
    for (int i = 0; i < 64; i++) begin
      arf = mem_axi_arvalid && mem_axi_arready;
      @(posedge clk); #1;
      if (arf) begin mem_axi_arvalid = 1'b0; fired = 1; cnt = 0; end
      else if (fired) cnt++;
      if (fired && mem_axi_rvalid) begin lat = cnt; data = mem_axi_rdata; break; end
    end
    mem_axi_arvalid = 1'b0;
    if (lat >= 0) begin
      @(posedge clk); #1;
      timeout = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid, mem_axi_rdata,
         console_valid, console_data, tests_passed, addr_error} !== 49'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b rdata=%h flags=%b%b%b expected all zero",
               mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_bvalid, mem_axi_rvalid,
               mem_axi_rdata, console_valid, tests_passed, addr_error);
    end
    reset = 1'b0;
    checks++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_arready} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_release_edge: got %b expected 000",
               {mem_axi_awready, mem_axi_wready, mem_axi_arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 111",
               {mem_axi_awready, mem_axi_wready, mem_axi_arready});
    end
  endtask

  task automatic test_basic_rw();
    int lat; bit wl, to; logic [31:0] d, exp_d;
    write_txn(32'h100, 32'hA5A5_1234, 4'hF, 0, lat, wl, to);
    checks++;
    if (to !== 1'b0 || lat != LATENCY + 1) begin
      errors++; $display("FAIL basic_b_latency: got %0d expected %0d", lat, LATENCY + 1);
    end
    checks++;
    if ({mem_axi_bvalid, mem_axi_awready, mem_axi_wready} !== 3'b011) begin
      errors++; $display("FAIL basic_after_b: got %b expected 011",
                         {mem_axi_bvalid, mem_axi_awready, mem_axi_wready});
    end
    exp_d = model_read(32'h100);
    read_txn(32'h100, d, lat, to);
    checks++;
    if (to !== 1'b0 || lat != LATENCY + 1) begin
      errors++; $display("FAIL basic_r_latency: got %0d expected %0d", lat, LATENCY + 1);
    end
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL basic_rdata: got %h expected %h", d, exp_d);
    end
    checks++;
    if ({mem_axi_rvalid, mem_axi_arready} !== 2'b01) begin
      errors++; $display("FAIL basic_after_r: got %b expected 01", {mem_axi_rvalid, mem_axi_arready});
    end
  endtask

  task automatic test_strobe_order();
    int lat; bit wl, to; logic [31:0] d, exp_d;
    write_txn(32'h180, 32'h1111_1111, 4'hF, 0, lat, wl, to);
    write_txn(32'h180, 32'h0000_BB00, 4'b0010, 2, lat, wl, to);
    checks++;
    if (to !== 1'b0 || lat != LATENCY + 1) begin
      errors++; $display("FAIL w_first_latency: got %0d expected %0d", lat, LATENCY + 1);
    end
    checks++;
    if (wl !== 1'b1) begin
      errors++; $display("FAIL wready_held_low: got wready high expected low until B");
    end
    exp_d = model_read(32'h180);
    read_txn(32'h180, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL strobe_merge: got %h expected %h", d, exp_d);
    end
    write_txn(32'h182, 32'hFFFF_FFFF, 4'h0, 1, lat, wl, to);
    exp_d = model_read(32'h180);
    read_txn(32'h180, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL zero_strobe: got %h expected %h", d, exp_d);
    end
  endtask

  task automatic test_console_pass();
    int lat, c0; bit wl, to; logic [31:0] d;
    c0 = cons_count;
    write_txn(CONSOLE_ADDR, {$urandom_range(0, 255) & 32'hFF, 24'h0000_48}, 4'hF, 0, lat, wl, to);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cons_count - c0 != 1) begin
      errors++; $display("FAIL console_pulse_cycles: got %0d expected 1", cons_count - c0);
    end
    checks++;
    if (cons_last !== 8'h48) begin
      errors++; $display("FAIL console_data: got %h expected 48", cons_last);
    end
    write_txn(PASS_ADDR, 32'd5, 4'hF, 0, lat, wl, to);
    checks++;
    if (tests_passed !== model_pass) begin
      errors++; $display("FAIL pass_wrong_value: got %b expected %b", tests_passed, model_pass);
    end
    write_txn(PASS_ADDR, PASS_VALUE, 4'hF, 1, lat, wl, to);
    checks++;
    if (tests_passed !== model_pass) begin
      errors++; $display("FAIL pass_set: got %b expected %b", tests_passed, model_pass);
    end
    write_txn(PASS_ADDR, 32'd5, 4'hF, 0, lat, wl, to);
    checks++;
    if (tests_passed !== model_pass) begin
      errors++; $display("FAIL pass_sticky: got %b expected %b", tests_passed, model_pass);
    end
    read_txn(CONSOLE_ADDR, d, lat, to);
    checks++;
    if (d !== model_read(CONSOLE_ADDR)) begin
      errors++; $display("FAIL console_read_zero: got %h expected 0", d);
    end
    checks++;
    if (addr_error !== model_err) begin
      errors++; $display("FAIL special_no_error: got %b expected %b", addr_error, model_err);
    end
  endtask

  task automatic test_out_of_range();
    int lat; bit wl, to; logic [31:0] d, exp_d, oor;
    oor = 32'(4 * MEM_WORDS);
    write_txn(32'h0, 32'hCAFE_F00D, 4'hF, 0, lat, wl, to);
    exp_d = model_read(oor);
    read_txn(oor, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL oor_read_data: got %h expected %h", d, exp_d);
    end
    checks++;
    if (addr_error !== model_err) begin
      errors++; $display("FAIL oor_read_flag: got %b expected %b", addr_error, model_err);
    end
    write_txn(oor, 32'h1234_5678, 4'hF, 0, lat, wl, to);
    checks++;
    if (to !== 1'b0 || lat != LATENCY + 1) begin
      errors++; $display("FAIL oor_write_bvalid: got lat %0d expected %0d", lat, LATENCY + 1);
    end
    exp_d = model_read(32'h0);
    read_txn(32'h0, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL oor_write_no_alias: got %h expected %h", d, exp_d);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit wl, to, awf, wf, arf; logic [31:0] d, old_d, exp_d;
    write_txn(32'h300, 32'h0BAD_BEEF, 4'hF, 0, lat, wl, to);
    old_d = model_read(32'h300);
    mem_axi_bready = 1'b0; mem_axi_rready = 1'b0;
    mem_axi_awaddr = 32'h300; mem_axi_wdata = 32'h1234_5678; mem_axi_wstrb = 4'hF;
    mem_axi_awvalid = 1'b1; mem_axi_wvalid = 1'b1;
    mem_axi_araddr = 32'h300; mem_axi_arvalid = 1'b1;
    for (int i = 0; i < 20 && !(mem_axi_bvalid && mem_axi_rvalid); i++) begin
      awf = mem_axi_awvalid && mem_axi_awready;
      wf  = mem_axi_wvalid && mem_axi_wready;
      arf = mem_axi_arvalid && mem_axi_arready;
      @(posedge clk); #1;
      if (awf) mem_axi_awvalid = 1'b0;
      if (wf)  mem_axi_wvalid  = 1'b0;
      if (arf) mem_axi_arvalid = 1'b0;
    end
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0;
    model_write(32'h300, 32'h1234_5678, 4'hF);
    checks++;
    if ({mem_axi_bvalid, mem_axi_rvalid, mem_axi_rdata} !== {2'b11, old_d}) begin
      errors++; $display("FAIL same_edge_old_data: got bv=%b rv=%b %h expected bv=1 rv=1 %h",
                         mem_axi_bvalid, mem_axi_rvalid, mem_axi_rdata, old_d);
    end
    mem_axi_araddr = 32'h100; mem_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_axi_bvalid, mem_axi_rvalid, mem_axi_arready, mem_axi_awready, mem_axi_wready, mem_axi_rdata}
          !== {5'b11000, old_d}) begin
        errors++; $display("FAIL hold_cycle_%0d: got %b %h expected 11000 %h", i,
                           {mem_axi_bvalid, mem_axi_rvalid, mem_axi_arready, mem_axi_awready, mem_axi_wready},
                           mem_axi_rdata, old_d);
      end
    end
    mem_axi_rready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_axi_rvalid, mem_axi_arready, mem_axi_bvalid} !== 3'b011) begin
      errors++; $display("FAIL after_r_handshake: got %b expected 011",
                         {mem_axi_rvalid, mem_axi_arready, mem_axi_bvalid});
    end
    @(posedge clk); #1;
    mem_axi_arvalid = 1'b0;
    checks++;
    if (mem_axi_arready !== 1'b0) begin
      errors++; $display("FAIL next_ar_accepted: got arready %b expected 0", mem_axi_arready);
    end
    exp_d = model_read(32'h100);
    for (int i = 0; i < 16 && !mem_axi_rvalid; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({mem_axi_rvalid, mem_axi_rdata} !== {1'b1, exp_d}) begin
      errors++; $display("FAIL second_read: got rv=%b %h expected rv=1 %h", mem_axi_rvalid, mem_axi_rdata, exp_d);
    end
    @(posedge clk); #1;
    mem_axi_bready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_axi_bvalid, mem_axi_awready, mem_axi_wready} !== 3'b011) begin
      errors++; $display("FAIL after_b_release: got %b expected 011",
                         {mem_axi_bvalid, mem_axi_awready, mem_axi_wready});
    end
    exp_d = model_read(32'h300);
    read_txn(32'h300, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL write_after_concurrent: got %h expected %h", d, exp_d);
    end
  endtask

  task automatic test_mid_reset();
    int lat; bit to; logic [31:0] d, exp_d;
    mem_axi_bready = 1'b1; mem_axi_rready = 1'b1;
    mem_axi_awaddr = 32'h100; mem_axi_wdata = 32'hDEAD_DEAD; mem_axi_wstrb = 4'hF;
    mem_axi_awvalid = 1'b1; mem_axi_wvalid = 1'b1;
    mem_axi_araddr = 32'h180; mem_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0; mem_axi_arvalid = 1'b0;
    reset = 1'b1;
    model_pass = 1'b0; model_err = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_bvalid, mem_axi_rvalid} !== 5'b00000) begin
      errors++; $display("FAIL mid_reset_outputs: got %b expected 00000",
                         {mem_axi_awready, mem_axi_wready, mem_axi_arready, mem_axi_bvalid, mem_axi_rvalid});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_arready} !== 3'b111) begin
      errors++; $display("FAIL mid_reset_readies: got %b expected 111",
                         {mem_axi_awready, mem_axi_wready, mem_axi_arready});
    end
    checks++;
    if ({tests_passed, addr_error} !== {model_pass, model_err}) begin
      errors++; $display("FAIL flags_cleared: got %b expected %b", {tests_passed, addr_error}, {model_pass, model_err});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_axi_bvalid, mem_axi_rvalid} !== 2'b00) begin
        errors++; $display("FAIL stale_response_%0d: got %b expected 00", i, {mem_axi_bvalid, mem_axi_rvalid});
      end
    end
    exp_d = model_read(32'h100);
    read_txn(32'h100, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL aborted_write_ram: got %h expected %h", d, exp_d);
    end
    exp_d = model_read(32'h180);
    read_txn(32'h180, d, lat, to);
    checks++;
    if (d !== exp_d) begin
      errors++; $display("FAIL ram_after_reset: got %h expected %h", d, exp_d);
    end
  endtask

  task automatic test_random();
    int lat; bit wl, to; logic [31:0] a, d, exp_d;
    for (int k = 0; k < 8; k++) write_txn(32'h400 + 32'(4 * k), $urandom, 4'hF, 0, lat, wl, to);
    for (int n = 0; n < 40; n++) begin
      a = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'(4 * MEM_WORDS) + 32'(4 * $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        write_txn(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), lat, wl, to);
        checks++;
        if (to !== 1'b0 || lat != LATENCY + 1 || wl !== 1'b1) begin
          errors++; $display("FAIL rand_write_%0d: got lat %0d wlow %b expected lat %0d wlow 1",
                             n, lat, wl, LATENCY + 1);
        end
      end else begin
        exp_d = model_read(a);
        read_txn(a, d, lat, to);
        checks++;
        if (to !== 1'b0 || lat != LATENCY + 1 || d !== exp_d) begin
          errors++; $display("FAIL rand_read_%0d @%h: got %h lat %0d expected %h lat %0d",
                             n, a, d, lat, exp_d, LATENCY + 1);
        end
      end
    end
    checks++;
    if ({tests_passed, addr_error} !== {model_pass, model_err}) begin
      errors++; $display("FAIL rand_flags: got %b expected %b", {tests_passed, addr_error}, {model_pass, model_err});
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_axi_awvalid = 1'b0; mem_axi_awaddr = '0; mem_axi_awprot = '0;
    mem_axi_wvalid = 1'b0; mem_axi_wdata = '0; mem_axi_wstrb = '0;
    mem_axi_bready = 1'b0;
    mem_axi_arvalid = 1'b0; mem_axi_araddr = '0; mem_axi_arprot = '0;
    mem_axi_rready = 1'b0;
    test_reset();
    test_basic_rw();
    test_strobe_order();
    test_console_pass();
    test_out_of_range();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
